// File: rtl/multiplier.sv
// Multi-cycle radix-2 shift-add multiplier, signed/unsigned.
// Start/busy handshake; result held until the next completed operation.
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  input  logic             i_is_unsigned,
  input  logic             i_mul_start,
  output logic [WIDTH-1:0] o_product_hi,
  output logic [WIDTH-1:0] o_product_lo,
  output logic             o_mul_busy,
  output logic             o_mul_done
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               a_neg, b_neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = ~i_is_unsigned & i_multiplicand[WIDTH-1];
  assign b_neg = ~i_is_unsigned & i_multiplier[WIDTH-1];
  assign a_abs = a_neg ? (~i_multiplicand + 1'b1) : i_multiplicand;
  assign b_abs = b_neg ? (~i_multiplier + 1'b1) : i_multiplier;

  // Next-state, datapath step and result fix-up.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, a_q} : '0);
    prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
    unique case (state_q)
      IDLE: begin
        if (i_mul_start) begin
          a_d     = a_abs;
          acc_d   = {{WIDTH{1'b0}}, b_abs};
          neg_d   = a_neg ^ b_neg;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign o_product_hi = hi_q;
  assign o_product_lo = lo_q;
  assign o_mul_busy   = (state_q != IDLE);
  assign o_mul_done   = done_q;

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: vector table, scoreboard queue,
// handshake and reset corner sequences.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] a, b;
  logic        uns;
  logic        start;
  logic [31:0] hi, lo;
  logic        busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] sb_q[$];
  logic [63:0] prev;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  multiplier #(.WIDTH(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .i_multiplicand (a),
    .i_multiplier   (b),
    .i_is_unsigned  (uns),
    .i_mul_start    (start),
    .o_product_hi   (hi),
    .o_product_lo   (lo),
    .o_mul_busy     (busy),
    .o_mul_done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        u
  );
    logic signed [63:0] sx, sy;
    if (u) return {32'b0, x} * {32'b0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    return sx * sy;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one op at the current negedge; returns at the
  // negedge of the done cycle. disturb re-asserts start
  // with other operands mid-CALC.
  task automatic do_op(input string name,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic        u,
                       input logic [63:0] exp,
                       input bit          disturb);
    int n;
    bit busy_ok;
    logic [63:0] got;
    a = x; b = y; uns = u; start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({name, " done_low_after_start"}, {63'b0, done}, 64'd0);
    n = 0;
    busy_ok = 1'b1;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (disturb && n == 5) begin
        start = 1'b1;
        a = 32'h1234_5678;
        b = 32'h0000_0003;
        uns = ~u;
      end
      if (disturb && n == 8) start = 1'b0;
      if (n == 16)
        chk({name, " held"}, {hi, lo}, prev);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (n > 40) break;
    end
    chk({name, " latency"}, 64'(n), 64'd33);
    chk({name, " busy_during_op"}, {63'b0, busy_ok}, 64'd1);
    chk({name, " busy_low_at_done"}, {63'b0, busy}, 64'd0);
    got = sb_q.size() > 0 ? sb_q.pop_front() : 64'hx;
    chk({name, " product"}, {hi, lo}, got);
    prev = got;
  endtask

  task automatic idle_check(input string name);
    @(posedge clk);
    @(negedge clk);
    chk({name, " done_pulse_end"}, {63'b0, done}, 64'd0);
    chk({name, " idle_busy"}, {63'b0, busy}, 64'd0);
    chk({name, " result_kept"}, {hi, lo}, prev);
  endtask

  initial begin
    bit seen_done;
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[4] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'h0000_0006_FFFF_FFEB};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0};
    vecs[6] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780};
    vecs[7] = '{32'h8000_0000, 32'h0000_0002, 1'b1, 64'h0000_0001_0000_0000};
    vecs[8] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 64'hFFFF_FFFF_8000_0000};
    vecs[9] = '{32'h0000_0006, 32'h0000_0007, 1'b0, 64'd42};

    a = '0; b = '0; uns = 1'b0; start = 1'b0;
    prev = '0;
    resetn = 1'b0;
    #23;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_state", {busy, done, hi, lo}, 66'd0);
    end

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
            vecs[i].uns, vecs[i].exp, 1'b0);
      idle_check($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      logic [31:0] x, y;
      logic u;
      x = $urandom;
      y = $urandom;
      u = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", i), x, y, u, model(x, y, u), 1'b0);
    end
    idle_check("rnd");

    do_op("restart_ignored", 32'h0000_0007, 32'hFFFF_FFFD,
          1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    idle_check("restart_ignored");

    do_op("b2b_first", 32'h0000_0003, 32'h0000_0005,
          1'b1, 64'd15, 1'b0);
    do_op("b2b_second", 32'hFFFF_FFFE, 32'h0000_0009,
          1'b0, 64'hFFFF_FFFF_FFFF_FFEE, 1'b0);
    idle_check("b2b");

    a = 32'd7; b = 32'hFFFF_FFFD; uns = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, hi, lo}, 66'd0);
    sb_q.delete();
    prev = '0;
    @(negedge clk);
    resetn = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("no_done_after_reset", {63'b0, seen_done}, 64'd0);
    do_op("after_reset", 32'd6, 32'd7, 1'b0, 64'd42, 1'b0);
    idle_check("after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
